// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } rst_seq_state_t;

    // Wide enough to hold the larger of the two cycle counts.
    function automatic int cnt_width(input int min_assert, input int gap);
        int m;
        m = (min_assert > gap) ? min_assert : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Reset synchroniser: asynchronous assert, release after NO_OF_SYNC_STAGES clk edges.
module rst_sync_cell #(
    parameter int NO_OF_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_async_n,
    output logic sync_ok
);

    logic [NO_OF_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NO_OF_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[NO_OF_SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Multi-channel reset synchroniser and in-order release sequencer.
// Optional software re-sequence from DONE is built when RST_SEQ_SW_RST_EN is defined.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int NO_OF_SYNC_STAGES = 2,
    parameter int NUM_CHANNELS      = 4,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int RELEASE_GAP       = 8
) (
    input  logic                    clk,
    input  logic                    rst_async_n,
    output logic [NUM_CHANNELS-1:0] rst_sync_n,
    output logic                    rst_done
`ifdef RST_SEQ_SW_RST_EN
    ,
    input  logic                    sw_rst_req,
    output logic                    sw_rst_ack
`endif
);

    localparam int CW = cnt_width(MIN_ASSERT_CYCLES, RELEASE_GAP);
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                    sync_ok;
    rst_seq_state_t          state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d, idx_nxt;
    logic [NUM_CHANNELS-1:0] rst_q, rst_d;
    logic                    done_q, done_d;
    logic                    ack_q, ack_d;

    rst_sync_cell #(
        .NO_OF_SYNC_STAGES(NO_OF_SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .sync_ok    (sync_ok)
    );

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        case (state_q)
            HOLD: begin
                if (sync_ok) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                if (cnt_q == CW'(MIN_ASSERT_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    rst_d = NUM_CHANNELS'(1);
                    if (NUM_CHANNELS == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_nxt;
                    // Released channels form a thermometer code, so shifting in a one releases the next.
                    rst_d = (rst_q << 1) | NUM_CHANNELS'(1);
                    if (idx_nxt == IW'(NUM_CHANNELS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
`ifdef RST_SEQ_SW_RST_EN
                // Synchroniser is left alone: the clock domain is already live.
                if (sw_rst_req) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                end
`endif
            end
            default: state_d = HOLD;
        endcase
    end

    assign rst_sync_n = rst_q;
    assign rst_done   = done_q;
`ifdef RST_SEQ_SW_RST_EN
    assign sw_rst_ack = ack_q;
`endif

endmodule

// File: tb/tb_rst_seq_sync.sv
// Directed bench for rst_seq_sync: default 4-channel instance plus a 1-channel corner instance.
module tb_rst_seq_sync;

    logic       clk = 1'b0;
    logic       rst_async_n;
    logic       rst1_n;
    logic [3:0] rst_sync_n;
    logic       rst_done;
    logic [0:0] rst1_sync_n;
    logic       rst1_done;
`ifdef RST_SEQ_SW_RST_EN
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       sw1_req;
    logic       sw1_ack;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rst_seq_sync dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .rst_sync_n (rst_sync_n),
        .rst_done   (rst_done)
`ifdef RST_SEQ_SW_RST_EN
        ,
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack)
`endif
    );

    rst_seq_sync #(
        .NO_OF_SYNC_STAGES(3),
        .NUM_CHANNELS     (1),
        .MIN_ASSERT_CYCLES(1),
        .RELEASE_GAP      (8)
    ) dut1 (
        .clk        (clk),
        .rst_async_n(rst1_n),
        .rst_sync_n (rst1_sync_n),
        .rst_done   (rst1_done)
`ifdef RST_SEQ_SW_RST_EN
        ,
        .sw_rst_req (sw1_req),
        .sw_rst_ack (sw1_ack)
`endif
    );

    // Default parameters: channel k is released base + 8*k edges into the sequence.
    function automatic logic [3:0] exp_vec(input int e, input int base);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k] = (e >= base + 8 * k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_async_n = 1'b0;
        rst1_n      = 1'b0;
`ifdef RST_SEQ_SW_RST_EN
        sw_rst_req  = 1'b0;
        sw1_req     = 1'b0;
`endif
        repeat (3) tick();
        total++;
        if (rst_sync_n !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rst_sync_n: got %b want 0000", rst_sync_n);
        end
        total++;
        if (rst_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_rst_done: got %b want 0", rst_done);
        end
        total++;
        if (rst1_sync_n !== 1'b0 || rst1_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_single: got %b/%b want 0/0", rst1_sync_n, rst1_done);
        end
`ifdef RST_SEQ_SW_RST_EN
        total++;
        if (sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack: got %b want 0", sw_rst_ack);
        end
`endif
    endtask

    task automatic test_single_channel();
        @(negedge clk);
        rst1_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (rst1_sync_n !== 1'(e >= 5) || rst1_done !== 1'(e >= 5)) begin
                bad++;
                $display("FAIL single_ch edge %0d: got %b/%b want %b/%b",
                         e, rst1_sync_n, rst1_done, 1'(e >= 5), 1'(e >= 5));
            end
        end
    endtask

    task automatic test_power_on();
        @(negedge clk);
        rst_async_n = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            total++;
            if (rst_sync_n !== exp_vec(e, 19) || rst_done !== 1'(e >= 43)) begin
                bad++;
                $display("FAIL power_on edge %0d: got %b done=%b want %b done=%b",
                         e, rst_sync_n, rst_done, exp_vec(e, 19), 1'(e >= 43));
            end
        end
    endtask

    task automatic test_async_assert();
        rst_async_n = 1'b0;
        tick();
        @(negedge clk);
        rst_async_n = 1'b1;
        repeat (30) tick();
        total++;
        if (rst_sync_n !== 4'b0011) begin
            bad++;
            $display("FAIL async_pre edge 30: got %b want 0011", rst_sync_n);
        end
        #2;
        rst_async_n = 1'b0;
        #1;
        total++;
        if (rst_sync_n !== 4'b0000 || rst_done !== 1'b0) begin
            bad++;
            $display("FAIL async_assert: got %b done=%b want 0000 done=0", rst_sync_n, rst_done);
        end
        repeat (10) tick();
        total++;
        if (rst_sync_n !== 4'b0000) begin
            bad++;
            $display("FAIL async_held edge 40: got %b want 0000", rst_sync_n);
        end
        @(negedge clk);
        rst_async_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            total++;
            if (rst_sync_n !== exp_vec(e, 19)) begin
                bad++;
                $display("FAIL async_restart edge %0d: got %b want %b", 40 + e, rst_sync_n, exp_vec(e, 19));
            end
        end
    endtask

    task automatic test_glitch();
        repeat (25) tick();
        total++;
        if (rst_done !== 1'b1 || rst_sync_n !== 4'b1111) begin
            bad++;
            $display("FAIL glitch_pre: got %b done=%b want 1111 done=1", rst_sync_n, rst_done);
        end
        #2;
        rst_async_n = 1'b0;
        #1;
        total++;
        if (rst_sync_n !== 4'b0000 || rst_done !== 1'b0) begin
            bad++;
            $display("FAIL glitch_clear: got %b done=%b want 0000 done=0", rst_sync_n, rst_done);
        end
        rst_async_n = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            total++;
            if (rst_sync_n !== exp_vec(e, 19) || rst_done !== 1'(e >= 43)) begin
                bad++;
                $display("FAIL glitch_restart edge %0d: got %b done=%b want %b done=%b",
                         e, rst_sync_n, rst_done, exp_vec(e, 19), 1'(e >= 43));
            end
        end
    endtask

`ifdef RST_SEQ_SW_RST_EN
    task automatic test_sw_reset();
        sw_rst_req = 1'b1;
        tick();
        total++;
        if (sw_rst_ack !== 1'b1 || rst_sync_n !== 4'b0000 || rst_done !== 1'b0) begin
            bad++;
            $display("FAIL sw_edge_S: ack=%b rst=%b done=%b want 1/0000/0", sw_rst_ack, rst_sync_n, rst_done);
        end
        sw_rst_req = 1'b0;
        tick();
        total++;
        if (sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL sw_ack_width: got %b want 0", sw_rst_ack);
        end
        for (int j = 2; j <= 42; j++) begin
            tick();
            total++;
            if (rst_sync_n !== exp_vec(j, 16) || rst_done !== 1'(j >= 40) || sw_rst_ack !== 1'b0) begin
                bad++;
                $display("FAIL sw_seq S+%0d: got %b done=%b ack=%b want %b done=%b ack=0",
                         j, rst_sync_n, rst_done, sw_rst_ack, exp_vec(j, 16), 1'(j >= 40));
            end
        end
    endtask

    task automatic test_sw_ignored();
        rst_async_n = 1'b0;
        tick();
        @(negedge clk);
        rst_async_n = 1'b1;
        repeat (25) tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        total++;
        if (sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL sw_ignored_ack: got %b want 0", sw_rst_ack);
        end
        for (int e = 27; e <= 45; e++) begin
            tick();
            total++;
            if (rst_sync_n !== exp_vec(e, 19) || rst_done !== 1'(e >= 43) || sw_rst_ack !== 1'b0) begin
                bad++;
                $display("FAIL sw_ignored edge %0d: got %b done=%b ack=%b want %b done=%b ack=0",
                         e, rst_sync_n, rst_done, sw_rst_ack, exp_vec(e, 19), 1'(e >= 43));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_power_on();
        test_async_assert();
        test_glitch();
`ifdef RST_SEQ_SW_RST_EN
        test_sw_reset();
        test_sw_ignored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
